// File: rtl/jellyvl_trigger_pkg.sv
// Shared widths and channel-index type for the periodic trigger scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jellyvl_trigger_pkg;
    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_TIMER_WIDTH  = 64;
    localparam int DEF_PERIOD_WIDTH = 32;
    localparam int MAX_CH           = 16;
    localparam int CH_IDX_W         = $clog2(MAX_CH);

    // Wide enough for any legal channel count; users slice down to $clog2(NUM_CH).
    typedef logic [CH_IDX_W-1:0] ch_idx_t;
endpackage

// File: rtl/jellyvl_periodic_trigger_scheduler_if.sv
// Event handshake bundle between the scheduler (master) and its consumer (slave).
// Latency: n/a (wires only).
// Backpressure: event_valid/event_ch must hold until event_ready is seen.
interface jellyvl_periodic_trigger_scheduler_if
    import jellyvl_trigger_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
);
    localparam int CH_W = $clog2(NUM_CH);

    logic            event_valid;
    logic [CH_W-1:0] event_ch;
    logic            event_ready;

    modport master (output event_valid, output event_ch, input event_ready);
    modport slave  (input event_valid, input event_ch, output event_ready);
endinterface

// File: rtl/jellyvl_rr_select.sv
// Round-robin pick of the first set request after last_i, wrapping at NUM_CH.
// Latency: combinational.
// Backpressure: none; found_o=0 when the request vector is empty.
// Ports: req_i request vector, last_i last granted index, grant_o chosen index, found_o any request.
module jellyvl_rr_select
    import jellyvl_trigger_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   last_i,
    output logic [CH_W-1:0]   grant_o,
    output logic              found_o
);
    ch_idx_t cand;

    // Scan from farthest to nearest so the nearest request after last_i wins.
    always_comb begin
        grant_o = last_i;
        found_o = 1'b0;
        cand    = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = ch_idx_t'((int'(last_i) + k) % NUM_CH);
            if (req_i[cand[CH_W-1:0]]) begin
                grant_o = cand[CH_W-1:0];
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/jellyvl_periodic_trigger_scheduler.sv
// Periodic trigger scheduler: one shared subtract/compare scans NUM_CH channels, pending events leave round-robin.
// Latency: 2 cycles from a firing evaluation to event_valid when idle; back-to-back events while ready stays high.
// Backpressure: event held until event_ready; a channel refiring while still pending sets its sticky overrun flag.
// Ports: rst/clk; enable, phase, period per channel; current_time (low PERIOD_WIDTH bits used);
//        evt carries event_valid/event_ch/event_ready; overrun flags with overrun_clear pulses.
module jellyvl_periodic_trigger_scheduler
    import jellyvl_trigger_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int TIMER_WIDTH    = DEF_TIMER_WIDTH,
    parameter int PERIOD_WIDTH   = DEF_PERIOD_WIDTH,
    parameter bit THRASHING_MASK = 1'b1
) (
    input  logic                                 rst,
    input  logic                                 clk,
    input  logic [NUM_CH-1:0]                    enable,
    input  logic [NUM_CH-1:0][PERIOD_WIDTH-1:0]  phase,
    input  logic [NUM_CH-1:0][PERIOD_WIDTH-1:0]  period,
    input  logic [TIMER_WIDTH-1:0]               current_time,
    jellyvl_periodic_trigger_scheduler_if.master evt,
    output logic [NUM_CH-1:0]                    overrun,
    input  logic [NUM_CH-1:0]                    overrun_clear
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [CH_W-1:0]         ch_sel_q, ch_sel_d;
    logic [PERIOD_WIDTH-1:0] base_q [NUM_CH];
    logic [PERIOD_WIDTH-1:0] base_d, base_sel, now_w, elapsed;
    logic [NUM_CH-1:0]       pending_q, pending_d, overrun_q, overrun_d, rr_req;
    logic                    ev_vld_q, ev_vld_d;
    logic [CH_W-1:0]         ev_ch_q, ev_ch_d, last_q, last_d, rr_grant;
    logic                    rr_found, accept, load;

    generate
        if (TIMER_WIDTH > PERIOD_WIDTH) begin : g_time_hi
            logic unused_time_hi;
            assign unused_time_hi = ^current_time[TIMER_WIDTH-1:PERIOD_WIDTH];
        end
    endgenerate

    assign now_w    = current_time[PERIOD_WIDTH-1:0];
    assign base_sel = base_q[ch_sel_q];
    // Modular difference keeps both time and base wrap-around correct.
    assign elapsed  = now_w - base_sel;
    assign accept   = ev_vld_q & evt.event_ready;
    assign load     = ~ev_vld_q | evt.event_ready;

    jellyvl_rr_select #(.NUM_CH(NUM_CH)) u_rr (
        .req_i   (rr_req),
        .last_i  (last_q),
        .grant_o (rr_grant),
        .found_o (rr_found)
    );

    always_comb begin
        ch_sel_d  = (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + 1'b1;
        base_d    = base_sel;
        pending_d = pending_q;
        // Clear first so a same-cycle overrun set wins.
        overrun_d = overrun_q & ~overrun_clear;

        if (accept) pending_d[ev_ch_q] = 1'b0;

        if (!enable[ch_sel_q]) begin
            base_d                = phase[ch_sel_q];
            pending_d[ch_sel_q]   = 1'b0;
        end else if (elapsed >= period[ch_sel_q]) begin
            base_d = base_sel + period[ch_sel_q];
            // Pre-update pending decides, even if this channel is being accepted now.
            if (!pending_q[ch_sel_q])  pending_d[ch_sel_q] = 1'b1;
            else if (THRASHING_MASK)   overrun_d[ch_sel_q] = 1'b1;
        end

        // The channel leaving on this handshake must not be re-presented.
        rr_req = pending_q;
        if (accept) rr_req[ev_ch_q] = 1'b0;

        ev_vld_d = ev_vld_q;
        ev_ch_d  = ev_ch_q;
        last_d   = last_q;
        if (load) begin
            ev_vld_d = rr_found;
            if (rr_found) begin
                ev_ch_d = rr_grant;
                last_d  = rr_grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_sel_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) base_q[i] <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            ev_vld_q  <= 1'b0;
            ev_ch_q   <= '0;
            last_q    <= CH_W'(NUM_CH - 1);
        end else begin
            ch_sel_q         <= ch_sel_d;
            base_q[ch_sel_q] <= base_d;
            pending_q        <= pending_d;
            overrun_q        <= overrun_d;
            ev_vld_q         <= ev_vld_d;
            ev_ch_q          <= ev_ch_d;
            last_q           <= last_d;
        end
    end

    assign evt.event_valid = ev_vld_q;
    assign evt.event_ch    = ev_ch_q;
    assign overrun         = overrun_q;
endmodule

// File: tb/tb_jellyvl_periodic_trigger_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle reference model.
// Latency: n/a.
// Backpressure: event_ready driven by the bench.
module tb_jellyvl_periodic_trigger_scheduler;
    import jellyvl_trigger_pkg::*;

    localparam int N  = 4;
    localparam int PW = 32;
    localparam int TW = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          enable;
    logic [N-1:0][PW-1:0]  phase;
    logic [N-1:0][PW-1:0]  period;
    logic [TW-1:0]         current_time;
    logic [N-1:0]          overrun;
    logic [N-1:0]          overrun_clear;

    jellyvl_periodic_trigger_scheduler_if #(.NUM_CH(N)) evt_if ();

    jellyvl_periodic_trigger_scheduler #(
        .NUM_CH(N), .TIMER_WIDTH(TW), .PERIOD_WIDTH(PW), .THRASHING_MASK(1'b1)
    ) dut (
        .rst           (rst),
        .clk           (clk),
        .enable        (enable),
        .phase         (phase),
        .period        (period),
        .current_time  (current_time),
        .evt           (evt_if.master),
        .overrun       (overrun),
        .overrun_clear (overrun_clear)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: per-channel base/pending/overrun, presented event, last grant, scan index.
    logic [PW-1:0] m_base [N];
    bit            m_pend [N];
    bit [N-1:0]    m_ovr;
    bit            m_vld;
    int            m_ch;
    int            m_last = N - 1;
    int            m_sel;

    // Handshake seen on the DUT port just before the most recent edge.
    bit            hs;
    int            hs_ch;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [PW-1:0] nb [N];
        bit            np [N];
        bit [N-1:0]    no;
        bit            nv, acc;
        int            nc, nl, ns, idx;
        logic [PW-1:0] el;
        hs    = (evt_if.event_valid === 1'b1) && (evt_if.event_ready === 1'b1);
        hs_ch = int'(evt_if.event_ch);
        if (rst) begin
            for (int i = 0; i < N; i++) begin nb[i] = '0; np[i] = 1'b0; end
            no = '0; nv = 1'b0; nc = 0; nl = N - 1; ns = 0;
        end else begin
            nb = m_base; np = m_pend; no = m_ovr & ~overrun_clear;
            nv = m_vld; nc = m_ch; nl = m_last;
            acc = m_vld && evt_if.event_ready;
            if (acc) np[m_ch] = 1'b0;
            el = current_time[PW-1:0] - m_base[m_sel];
            if (!enable[m_sel]) begin
                nb[m_sel] = phase[m_sel];
                np[m_sel] = 1'b0;
            end else if (el >= period[m_sel]) begin
                nb[m_sel] = m_base[m_sel] + period[m_sel];
                if (!m_pend[m_sel]) np[m_sel] = 1'b1;
                else                no[m_sel] = 1'b1;
            end
            if (!m_vld || evt_if.event_ready) begin
                nv = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (!nv && m_pend[idx] && !(acc && idx == m_ch)) begin
                        nv = 1'b1; nc = idx; nl = idx;
                    end
                end
            end
            ns = (m_sel + 1) % N;
        end
        @(posedge clk);
        m_base = nb; m_pend = np; m_ovr = no; m_vld = nv; m_ch = nc; m_last = nl; m_sel = ns;
        @(negedge clk);
        chk("model_valid", evt_if.event_valid, m_vld);
        if (m_vld) chk("model_ch", evt_if.event_ch, m_ch);
        chk("model_overrun", overrun, m_ovr);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = '0; overrun_clear = '0; evt_if.event_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt, last_n, exp_ch, mask, exp_mask, first_seen;
        logic [PW-1:0] tb_t;
        logic [TW-1:0] t_first;
        logic [TW-1:0] t_start;

        rst = 1'b1; enable = '0; phase = '0; period = '0; current_time = '0;
        overrun_clear = '0; evt_if.event_ready = 1'b0;

        // Reset state.
        do_reset();
        chk("rst_valid", evt_if.event_valid, 1'b0);
        chk("rst_ch", evt_if.event_ch, 0);
        chk("rst_overrun", overrun, 0);

        // Single channel, period 10, time +1 per cycle, always ready.
        phase = '0; period = '0; period[0] = 10; enable = 4'b0001; evt_if.event_ready = 1'b1;
        cnt = 0; last_n = -1;
        for (int n = 0; n < 210; n++) begin
            current_time = TW'(n);
            tick();
            if (hs) begin
                chk("a_ch", hs_ch, 0);
                if (last_n >= 0) chk("a_spacing_ok", ((n - last_n) >= 10 - (N - 1)) && ((n - last_n) <= 10 + (N - 1)), 1);
                last_n = n;
                cnt++;
            end
        end
        chk("a_count", cnt, 20);
        chk("a_overrun", overrun, 0);

        // All disabled: nothing fires, then each base must equal the phase loaded while disabled.
        do_reset();
        tb_t = $urandom;
        for (int i = 0; i < N; i++) begin
            logic [PW-1:0] d;
            d = (i == 0) ? 32'h70 : (i == 1) ? 32'h10 : PW'($urandom_range(0, 127));
            phase[i]  = tb_t - d;
            period[i] = 32'h40;
        end
        exp_mask = 0;
        for (int i = 0; i < N; i++)
            if ((tb_t - phase[i]) >= 32'h40) exp_mask |= (1 << i);
        for (int n = 0; n < 100; n++) begin
            current_time = {$urandom, $urandom};
            tick();
            chk("b_idle_valid", evt_if.event_valid, 1'b0);
        end
        current_time = {32'h0, tb_t}; enable = '1; evt_if.event_ready = 1'b1; mask = 0;
        for (int n = 0; n < 16; n++) begin
            tick();
            if (hs) mask |= (1 << hs_ch);
        end
        chk("b_fired_mask", mask, exp_mask);

        // Backpressure: one event held, refire sets overrun, exactly one acceptance, then clear.
        do_reset();
        phase = '0; period = '0; period[0] = 10; enable = 4'b0001; evt_if.event_ready = 1'b0;
        first_seen = 0;
        for (int n = 0; n < 50; n++) begin
            current_time = TW'(n);
            tick();
            if (first_seen) chk("c_hold", evt_if.event_valid && (evt_if.event_ch == 0), 1);
            if (evt_if.event_valid) first_seen = 1;
        end
        chk("c_seen", first_seen, 1);
        chk("c_overrun0", overrun[0], 1'b1);
        enable = '0; evt_if.event_ready = 1'b1; cnt = 0;
        for (int n = 50; n < 70; n++) begin
            current_time = TW'(n);
            tick();
            if (hs && hs_ch == 0) cnt++;
        end
        chk("c_one_accept", cnt, 1);
        chk("c_overrun_kept", overrun[0], 1'b1);
        overrun_clear = 4'b0001; tick();
        overrun_clear = '0; tick();
        chk("c_overrun_cleared", overrun[0], 1'b0);

        // Four equal channels: strict 0,1,2,3 acceptance order.
        do_reset();
        phase = '0; for (int i = 0; i < N; i++) period[i] = 8;
        enable = '1; evt_if.event_ready = 1'b1; exp_ch = 0;
        for (int n = 0; n < 100; n++) begin
            current_time = TW'(n);
            tick();
            if (hs) begin
                chk("d_order", hs_ch, exp_ch % N);
                exp_ch++;
            end
        end
        chk("d_count_ok", exp_ch >= 40, 1);
        chk("d_overrun", overrun, 0);

        // 32-bit wrap of time and base.
        do_reset();
        phase = '0; period = '0; phase[0] = 32'hFFFF_FFF0; period[0] = 32'h20;
        t_start = 64'hFFFF_FFF0; current_time = t_start;
        for (int n = 0; n < 4; n++) tick();
        enable = 4'b0001; evt_if.event_ready = 1'b1; cnt = 0; t_first = '0;
        for (int n = 0; n < 60; n++) begin
            current_time = t_start + TW'(n);
            tick();
            if (hs) begin
                if (cnt == 0) t_first = current_time;
                cnt++;
            end
        end
        chk("e_count", cnt, 1);
        chk("e_first_time_ok", (t_first >= 64'h1_0000_0010) && (t_first <= 64'h1_0000_0010 + N + 2), 1);

        // Reset while an event is presented and stalled.
        do_reset();
        phase = '0; period = '0; period[0] = 10; enable = 4'b0001; evt_if.event_ready = 1'b0;
        for (int n = 0; n < 30; n++) begin
            current_time = TW'(n);
            tick();
        end
        chk("f_pre_valid", evt_if.event_valid, 1'b1);
        chk("f_pre_overrun", overrun[0], 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("f_valid_dropped", evt_if.event_valid, 1'b0);
        chk("f_overrun_reset", overrun, 0);

        // Randomized traffic including period 0, random backpressure, clears and resets.
        do_reset();
        current_time = {$urandom, $urandom};
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) begin
                enable = N'($urandom);
                for (int i = 0; i < N; i++) begin
                    period[i] = PW'($urandom_range(0, 20));
                    phase[i]  = current_time[PW-1:0] - PW'($urandom_range(0, 30));
                end
            end
            evt_if.event_ready = ($urandom_range(0, 3) != 0);
            overrun_clear      = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            rst                = ($urandom_range(0, 499) == 0);
            current_time       = current_time + TW'($urandom_range(0, 3));
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
